// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle around the ID/EX operand register: ID-side operands, forwarding
// sources, pipeline control and the EX-side copies handed to source_operand.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 22,
  parameter int IS_W   = 4,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) ();
  logic              i_id_valid;
  logic [RA_W-1:0]   i_id_rs1;
  logic [RA_W-1:0]   i_id_rs2;
  logic              i_id_rs2_used;
  logic [DATA_W-1:0] i_id_pa;
  logic [DATA_W-1:0] i_id_pb;
  logic [IMM_W-1:0]  i_id_imm;
  logic [IS_W-1:0]   i_id_is;
  logic [RA_W-1:0]   i_id_rd;
  logic              i_id_we;
  logic              i_id_load;
  logic [DATA_W-1:0] i_ex_res;
  logic [DATA_W-1:0] i_mem_res;
  logic [DATA_W-1:0] i_wb_res;
  logic [RA_W-1:0]   i_mem_rd;
  logic [RA_W-1:0]   i_wb_rd;
  logic              i_mem_we;
  logic              i_wb_we;
  logic              i_ex_hold;
  logic              i_flush;
  logic              o_ex_valid;
  logic [DATA_W-1:0] o_ex_ra;
  logic [DATA_W-1:0] o_ex_r;
  logic [IMM_W-1:0]  o_ex_imm;
  logic [IS_W-1:0]   o_ex_is;
  logic [RA_W-1:0]   o_ex_rd;
  logic              o_ex_we;
  logic              o_ex_load;
  logic              o_stall;
  logic [CNT_W-1:0]  o_stall_cnt;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs2_used, i_id_pa, i_id_pb, i_id_imm,
           i_id_is, i_id_rd, i_id_we, i_id_load, i_ex_res, i_mem_res, i_wb_res,
           i_mem_rd, i_wb_rd, i_mem_we, i_wb_we, i_ex_hold, i_flush,
    input  o_ex_valid, o_ex_ra, o_ex_r, o_ex_imm, o_ex_is, o_ex_rd, o_ex_we, o_ex_load,
           o_stall, o_stall_cnt
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs2_used, i_id_pa, i_id_pb, i_id_imm,
           i_id_is, i_id_rd, i_id_we, i_id_load, i_ex_res, i_mem_res, i_wb_res,
           i_mem_rd, i_wb_rd, i_mem_we, i_wb_we, i_ex_hold, i_flush,
    output o_ex_valid, o_ex_ra, o_ex_r, o_ex_imm, o_ex_is, o_ex_rd, o_ex_we, o_ex_load,
           o_stall, o_stall_cnt
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: resolves rs1/rs2 through EX/MEM/WB forwarding, inserts a bubble
// on load-use, freezes on EX hold, kills on flush and counts stall cycles (saturating).
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 22,
  parameter int IS_W   = 4,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input logic                  i_clk,
  input logic                  i_reset,
  id_ex_operand_stage_if.slave bus
);
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_BUBBLE = 2'd1, ST_HOLD = 2'd2} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ex_valid;
  logic              r_ex_we;
  logic              r_ex_load;
  logic [DATA_W-1:0] r_ex_ra;
  logic [DATA_W-1:0] r_ex_r;
  logic [IMM_W-1:0]  r_ex_imm;
  logic [IS_W-1:0]   r_ex_is;
  logic [RA_W-1:0]   r_ex_rd;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_ex_fwd;
  logic              w_ex_ld;
  logic              w_hazard;
  logic              w_stall;
  logic              w_latch;
  logic              w_bubble;
  logic [DATA_W-1:0] w_ra;
  logic [DATA_W-1:0] w_r;

  // Register 0 reads as zero and is never a forwarding target; nearer stages win.
  function automatic logic [DATA_W-1:0] f_resolve(
    input logic [RA_W-1:0]   rs,
    input logic [DATA_W-1:0] rf_val,
    input logic              ex_fwd,
    input logic [RA_W-1:0]   ex_rd,
    input logic [DATA_W-1:0] ex_val,
    input logic              mem_we,
    input logic [RA_W-1:0]   mem_rd,
    input logic [DATA_W-1:0] mem_val,
    input logic              wb_we,
    input logic [RA_W-1:0]   wb_rd,
    input logic [DATA_W-1:0] wb_val
  );
    logic [DATA_W-1:0] v;
    if (rs == '0)                     v = '0;
    else if (ex_fwd && (ex_rd == rs)) v = ex_val;
    else if (mem_we && (mem_rd == rs)) v = mem_val;
    else if (wb_we && (wb_rd == rs))  v = wb_val;
    else                              v = rf_val;
    return v;
  endfunction

  assign w_ex_fwd = r_ex_valid & r_ex_we & ~r_ex_load;
  assign w_ex_ld  = r_ex_valid & r_ex_load & r_ex_we & (r_ex_rd != '0);
  assign w_hazard = bus.i_id_valid & w_ex_ld &
                    ((r_ex_rd == bus.i_id_rs1) | (bus.i_id_rs2_used & (r_ex_rd == bus.i_id_rs2)));
  assign w_stall  = bus.i_ex_hold | w_hazard;

  // Operand resolution for the instruction currently in ID
  always_comb begin
    w_ra = f_resolve(bus.i_id_rs1, bus.i_id_pa, w_ex_fwd, r_ex_rd, bus.i_ex_res,
                     bus.i_mem_we, bus.i_mem_rd, bus.i_mem_res,
                     bus.i_wb_we, bus.i_wb_rd, bus.i_wb_res);
    w_r  = f_resolve(bus.i_id_rs2, bus.i_id_pb, w_ex_fwd, r_ex_rd, bus.i_ex_res,
                     bus.i_mem_we, bus.i_mem_rd, bus.i_mem_res,
                     bus.i_wb_we, bus.i_wb_rd, bus.i_wb_res);
  end

  // Next-state and stage action: flush > hold > load-use bubble > latch ID
  always_comb begin
    w_state_nxt = ST_RUN;
    w_latch     = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      ST_RUN, ST_BUBBLE, ST_HOLD: begin
        if (bus.i_flush) begin
          w_bubble    = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (bus.i_ex_hold) begin
          w_state_nxt = ST_HOLD;
        end else if (w_hazard) begin
          w_bubble    = 1'b1;
          w_state_nxt = ST_BUBBLE;
        end else begin
          w_latch     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_bubble    = 1'b1;
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State, EX-side copies and stall counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_ex_valid  <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_ra     <= '0;
      r_ex_r      <= '0;
      r_ex_imm    <= '0;
      r_ex_is     <= '0;
      r_ex_rd     <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // A bubble keeps stale data but can never forward or hazard
      if (w_bubble) begin
        r_ex_valid <= 1'b0;
        r_ex_we    <= 1'b0;
        r_ex_load  <= 1'b0;
      end else if (w_latch) begin
        r_ex_valid <= bus.i_id_valid;
        r_ex_we    <= bus.i_id_valid & bus.i_id_we;
        r_ex_load  <= bus.i_id_valid & bus.i_id_load;
        r_ex_ra    <= w_ra;
        r_ex_r     <= w_r;
        r_ex_imm   <= bus.i_id_imm;
        r_ex_is    <= bus.i_id_is;
        r_ex_rd    <= bus.i_id_rd;
      end
    end
  end

  assign bus.o_ex_valid  = r_ex_valid;
  assign bus.o_ex_ra     = r_ex_ra;
  assign bus.o_ex_r      = r_ex_r;
  assign bus.o_ex_imm    = r_ex_imm;
  assign bus.o_ex_is     = r_ex_is;
  assign bus.o_ex_rd     = r_ex_rd;
  assign bus.o_ex_we     = r_ex_we;
  assign bus.o_ex_load   = r_ex_load;
  assign bus.o_stall     = w_stall;
  assign bus.o_stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: forwarding vector table, directed hazard,
// hold, flush and saturation sequences, then randomized traffic against a reference model.
module tb_id_ex_operand_stage;
  localparam int DATA_W    = 32;
  localparam int IMM_W     = 22;
  localparam int IS_W      = 4;
  localparam int RA_W      = 5;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX_I = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .IS_W(IS_W), .RA_W(RA_W),
                           .CNT_W(CNT_W)) bus ();

  id_ex_operand_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .IS_W(IS_W), .RA_W(RA_W),
                        .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Reference model of what EX should hold
  logic              m_valid, m_we, m_load;
  logic [DATA_W-1:0] m_ra, m_r;
  logic [IMM_W-1:0]  m_imm;
  logic [IS_W-1:0]   m_is;
  logic [RA_W-1:0]   m_rd;
  int                m_cnt;

  typedef struct {
    logic [RA_W-1:0]   rs1, rs2;
    logic [DATA_W-1:0] pa, pb;
    logic              mem_we;
    logic [RA_W-1:0]   mem_rd;
    logic [DATA_W-1:0] mem_res;
    logic              wb_we;
    logic [RA_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_res;
    logic [DATA_W-1:0] exp_ra, exp_r;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_resolve(input logic [RA_W-1:0] rs,
                                                  input logic [DATA_W-1:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (m_valid && m_we && !m_load && m_rd == rs) return bus.i_ex_res;
    if (bus.i_mem_we && bus.i_mem_rd == rs) return bus.i_mem_res;
    if (bus.i_wb_we && bus.i_wb_rd == rs) return bus.i_wb_res;
    return rf;
  endfunction

  function automatic logic m_hazard();
    return bus.i_id_valid && m_valid && m_load && m_we && (m_rd != 5'd0) &&
           (m_rd == bus.i_id_rs1 || (bus.i_id_rs2_used && m_rd == bus.i_id_rs2));
  endfunction

  // One clock: check comb stall, advance model, check registered outputs
  task automatic cycle();
    logic h, s;
    logic [DATA_W-1:0] nra, nr;
    #2;
    h   = m_hazard();
    s   = bus.i_ex_hold || h;
    nra = m_resolve(bus.i_id_rs1, bus.i_id_pa);
    nr  = m_resolve(bus.i_id_rs2, bus.i_id_pb);
    if (!rst) chk("stall", {63'd0, bus.o_stall}, {63'd0, s});
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_we = 1'b0; m_load = 1'b0; m_ra = '0; m_r = '0;
      m_imm = '0; m_is = '0; m_rd = '0; m_cnt = 0;
    end else begin
      if (s && m_cnt < CNT_MAX_I) m_cnt++;
      if (bus.i_flush || (!bus.i_ex_hold && h)) begin
        m_valid = 1'b0; m_we = 1'b0; m_load = 1'b0;
      end else if (!bus.i_ex_hold) begin
        m_valid = bus.i_id_valid;
        m_we    = bus.i_id_valid && bus.i_id_we;
        m_load  = bus.i_id_valid && bus.i_id_load;
        m_ra = nra; m_r = nr; m_imm = bus.i_id_imm; m_is = bus.i_id_is; m_rd = bus.i_id_rd;
      end
    end
    #1;
    chk("ex_valid", {63'd0, bus.o_ex_valid}, {63'd0, m_valid});
    chk("ex_we", {63'd0, bus.o_ex_we}, {63'd0, m_we});
    chk("ex_load", {63'd0, bus.o_ex_load}, {63'd0, m_load});
    chk("stall_cnt", 64'(bus.o_stall_cnt), 64'(m_cnt));
    if (m_valid) begin
      chk("ex_ra", 64'(bus.o_ex_ra), 64'(m_ra));
      chk("ex_r", 64'(bus.o_ex_r), 64'(m_r));
      chk("ex_imm", 64'(bus.o_ex_imm), 64'(m_imm));
      chk("ex_is", 64'(bus.o_ex_is), 64'(m_is));
      chk("ex_rd", 64'(bus.o_ex_rd), 64'(m_rd));
    end
  endtask

  task automatic idle();
    bus.i_id_valid = 1'b0; bus.i_id_rs1 = '0; bus.i_id_rs2 = '0; bus.i_id_rs2_used = 1'b1;
    bus.i_id_pa = '0; bus.i_id_pb = '0; bus.i_id_imm = '0; bus.i_id_is = '0;
    bus.i_id_rd = '0; bus.i_id_we = 1'b0; bus.i_id_load = 1'b0;
    bus.i_ex_res = '0; bus.i_mem_res = '0; bus.i_wb_res = '0;
    bus.i_mem_rd = '0; bus.i_wb_rd = '0; bus.i_mem_we = 1'b0; bus.i_wb_we = 1'b0;
    bus.i_ex_hold = 1'b0; bus.i_flush = 1'b0;
  endtask

  task automatic rand_inputs();
    logic [31:0] r32;
    bus.i_id_valid    = ($urandom_range(0, 9) != 0);
    bus.i_id_rs1      = RA_W'($urandom_range(0, 7));
    bus.i_id_rs2      = RA_W'($urandom_range(0, 7));
    bus.i_id_rs2_used = ($urandom_range(0, 1) == 1);
    bus.i_id_pa = $urandom; bus.i_id_pb = $urandom;
    r32 = $urandom; bus.i_id_imm = r32[IMM_W-1:0]; bus.i_id_is = r32[31:28];
    bus.i_id_rd   = RA_W'($urandom_range(0, 7));
    bus.i_id_we   = ($urandom_range(0, 3) != 0);
    bus.i_id_load = ($urandom_range(0, 2) == 0);
    bus.i_ex_res = $urandom; bus.i_mem_res = $urandom; bus.i_wb_res = $urandom;
    bus.i_mem_rd = RA_W'($urandom_range(0, 7));
    bus.i_wb_rd  = RA_W'($urandom_range(0, 7));
    bus.i_mem_we = ($urandom_range(0, 1) == 1);
    bus.i_wb_we  = ($urandom_range(0, 1) == 1);
    bus.i_ex_hold = ($urandom_range(0, 7) == 0);
    bus.i_flush   = ($urandom_range(0, 15) == 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1; cycle(); cycle();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5'd1, 5'd5, 32'h100, 32'h7, 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 32'h100, 32'h11};
    vecs[1] = '{5'd5, 5'd5, 32'h1, 32'h7, 1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 32'h22, 32'h22};
    vecs[2] = '{5'd2, 5'd6, 32'hA, 32'hB, 1'b1, 5'd2, 32'h33, 1'b1, 5'd6, 32'h44, 32'h33, 32'h44};
    vecs[3] = '{5'd0, 5'd0, 32'hDEAD, 32'hBEEF, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 32'h0, 32'h0};
    vecs[4] = '{5'd3, 5'd4, 32'h12, 32'h34, 1'b1, 5'd7, 32'h77, 1'b0, 5'd3, 32'h99, 32'h12, 32'h34};
    vecs[5] = '{5'd7, 5'd7, 32'h1, 32'h2, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h88, 32'h77, 32'h77};

    // Reset with random inputs
    rst = 1'b1;
    rand_inputs(); cycle();
    rand_inputs(); cycle();
    chk("rst_valid", {63'd0, bus.o_ex_valid}, 64'd0);
    chk("rst_ra", 64'(bus.o_ex_ra), 64'd0);
    chk("rst_r", 64'(bus.o_ex_r), 64'd0);
    chk("rst_imm", 64'(bus.o_ex_imm), 64'd0);
    chk("rst_is", 64'(bus.o_ex_is), 64'd0);
    chk("rst_rd", 64'(bus.o_ex_rd), 64'd0);
    chk("rst_we_load", {62'd0, bus.o_ex_we, bus.o_ex_load}, 64'd0);
    chk("rst_cnt", 64'(bus.o_stall_cnt), 64'd0);
    rst = 1'b0; idle(); #2;
    chk("rst_stall", {63'd0, bus.o_stall}, 64'd0);
    cycle();

    // Forwarding vector table (EX never writes, so only MEM/WB/RF compete)
    for (int i = 0; i < 6; i++) begin
      idle();
      bus.i_id_valid = 1'b1;
      bus.i_id_rs1 = vecs[i].rs1; bus.i_id_rs2 = vecs[i].rs2;
      bus.i_id_pa = vecs[i].pa; bus.i_id_pb = vecs[i].pb;
      bus.i_mem_we = vecs[i].mem_we; bus.i_mem_rd = vecs[i].mem_rd; bus.i_mem_res = vecs[i].mem_res;
      bus.i_wb_we = vecs[i].wb_we; bus.i_wb_rd = vecs[i].wb_rd; bus.i_wb_res = vecs[i].wb_res;
      cycle();
      chk($sformatf("vec%0d_ra", i), 64'(bus.o_ex_ra), 64'(vecs[i].exp_ra));
      chk($sformatf("vec%0d_r", i), 64'(bus.o_ex_r), 64'(vecs[i].exp_r));
    end

    // EX forward beats MEM/WB, then r0 stays zero
    idle(); bus.i_id_valid = 1'b1; bus.i_id_rd = 5'd5; bus.i_id_we = 1'b1;
    cycle();
    idle(); bus.i_id_valid = 1'b1; bus.i_id_rs2 = 5'd5; bus.i_id_pb = 32'h7;
    bus.i_mem_we = 1'b1; bus.i_mem_rd = 5'd5; bus.i_mem_res = 32'h11;
    bus.i_wb_we = 1'b1; bus.i_wb_rd = 5'd5; bus.i_wb_res = 32'h22; bus.i_ex_res = 32'h33;
    cycle();
    chk("fwd_ex", 64'(bus.o_ex_r), 64'h33);
    bus.i_id_rs2 = 5'd0; bus.i_id_pb = 32'h55; bus.i_mem_rd = 5'd0; bus.i_wb_rd = 5'd0;
    cycle();
    chk("fwd_r0", 64'(bus.o_ex_r), 64'h0);

    // Load-use: one bubble, then MEM forward
    do_reset();
    bus.i_id_valid = 1'b1; bus.i_id_rd = 5'd3; bus.i_id_we = 1'b1; bus.i_id_load = 1'b1;
    cycle();
    idle(); bus.i_id_valid = 1'b1; bus.i_id_rs1 = 5'd3; bus.i_id_pa = 32'h1; bus.i_id_rd = 5'd4;
    #2; chk("lu_stall", {63'd0, bus.o_stall}, 64'd1);
    cycle();
    chk("lu_bubble", {63'd0, bus.o_ex_valid}, 64'd0);
    bus.i_mem_we = 1'b1; bus.i_mem_rd = 5'd3; bus.i_mem_res = 32'hABCD;
    #2; chk("lu_stall_clr", {63'd0, bus.o_stall}, 64'd0);
    cycle();
    chk("lu_ra", 64'(bus.o_ex_ra), 64'hABCD);
    chk("lu_valid", {63'd0, bus.o_ex_valid}, 64'd1);
    chk("lu_cnt", 64'(bus.o_stall_cnt), 64'd1);

    // Hold for 3 cycles with ID changing, then release latches current ID
    do_reset();
    bus.i_id_valid = 1'b1; bus.i_id_rs1 = 5'd1; bus.i_id_pa = 32'h10; bus.i_id_rs2 = 5'd2;
    bus.i_id_pb = 32'h20; bus.i_id_imm = 22'h123; bus.i_id_is = 4'd3; bus.i_id_rd = 5'd6;
    bus.i_id_we = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); bus.i_ex_hold = 1'b1; bus.i_flush = 1'b0;
      #2; chk("hold_stall", {63'd0, bus.o_stall}, 64'd1);
      cycle();
      chk("hold_ra", 64'(bus.o_ex_ra), 64'h10);
      chk("hold_imm", 64'(bus.o_ex_imm), 64'h123);
      chk("hold_rd", 64'(bus.o_ex_rd), 64'd6);
    end
    chk("hold_cnt", 64'(bus.o_stall_cnt), 64'd3);
    idle(); bus.i_id_valid = 1'b1; bus.i_id_is = 4'b1010; bus.i_id_imm = 22'h3FFFFF;
    cycle();
    chk("rel_is", 64'(bus.o_ex_is), 64'hA);
    chk("rel_imm", 64'(bus.o_ex_imm), 64'h3FFFFF);
    chk("rel_cnt", 64'(bus.o_stall_cnt), 64'd3);

    // Flush beats hazard and hold; next cycle latches normally
    do_reset();
    bus.i_id_valid = 1'b1; bus.i_id_rd = 5'd3; bus.i_id_we = 1'b1; bus.i_id_load = 1'b1;
    cycle();
    idle(); bus.i_id_valid = 1'b1; bus.i_id_rs1 = 5'd3; bus.i_ex_hold = 1'b1; bus.i_flush = 1'b1;
    cycle();
    chk("fl_valid", {63'd0, bus.o_ex_valid}, 64'd0);
    chk("fl_we", {63'd0, bus.o_ex_we}, 64'd0);
    idle(); bus.i_id_valid = 1'b1; bus.i_id_rs1 = 5'd1; bus.i_id_pa = 32'h5; bus.i_id_we = 1'b1;
    cycle();
    chk("fl_run_valid", {63'd0, bus.o_ex_valid}, 64'd1);
    chk("fl_run_ra", 64'(bus.o_ex_ra), 64'h5);

    // Counter saturation
    do_reset();
    bus.i_ex_hold = 1'b1;
    for (int i = 0; i < 15; i++) cycle();
    chk("sat_15", 64'(bus.o_stall_cnt), 64'hF);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("sat_hold", 64'(bus.o_stall_cnt), 64'hF);
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
